// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and default constants for the 6502 datapath blocks.
//   pc_state_t      - program counter sequencing state (RUN / FIX)
//   fix_dir_t       - page fix-up direction produced by the lane adder
//   PC_RESET_VECTOR - default PC after reset
//   PC_LANE_W       - default lane (byte) width, also the branch offset width
package cpu_pkg;

  typedef enum logic {
    RUN = 1'b0,
    FIX = 1'b1
  } pc_state_t;

  typedef enum logic [1:0] {
    FIX_NONE = 2'b00,
    FIX_INC  = 2'b01,
    FIX_DEC  = 2'b10
  } fix_dir_t;

  localparam logic [15:0] PC_RESET_VECTOR = 16'hFFFC;
  localparam int          PC_LANE_W       = 8;

endpackage

// File: rtl/pc_lane_adder.sv
// pc_lane_adder: adds a signed LANE_W-bit offset to the lowest PC lane and
// reports whether the upper lanes need a +1 / -1 fix-up (page crossing).
//   lane_in  - current lowest lane of the PC
//   offset   - signed two's-complement branch offset
//   sum      - new lowest lane (modulo 2^LANE_W)
//   fix_dir  - FIX_NONE, FIX_INC (carry with offset >= 0) or
//              FIX_DEC (no carry with offset < 0)
module pc_lane_adder
  import cpu_pkg::*;
#(
  parameter int LANE_W = PC_LANE_W
) (
  input  logic [LANE_W-1:0] lane_in,
  input  logic [LANE_W-1:0] offset,
  output logic [LANE_W-1:0] sum,
  output fix_dir_t          fix_dir
);

  logic [LANE_W:0] wide_sum_s;
  logic            carry_s;
  logic            offset_neg_s;

  // Unsigned add with carry out; the offset sign decides how the carry reads.
  always_comb begin
    wide_sum_s   = {1'b0, lane_in} + {1'b0, offset};
    carry_s      = wide_sum_s[LANE_W];
    offset_neg_s = offset[LANE_W-1];
    sum          = wide_sum_s[LANE_W-1:0];
    // A negative offset is added as 2^LANE_W - |offset|, so a borrow shows
    // up as the absence of carry.
    if (!offset_neg_s && carry_s) begin
      fix_dir = FIX_INC;
    end else if (offset_neg_s && !carry_s) begin
      fix_dir = FIX_DEC;
    end else begin
      fix_dir = FIX_NONE;
    end
  end

endmodule

// File: rtl/program_counter_ext.sv
// program_counter_ext: parametrised lane-split program counter.
//   clk, reset_n - rising-edge clock, asynchronous active-low reset
//   pc_in        - parallel load data
//   lane_load    - per-lane load mask (bit k loads lane k of pc_in)
//   inc_enable   - increment PC by one
//   branch       - start a relative branch by the signed offset
//   offset       - signed branch offset (LANE_W bits)
//   pc_out       - current PC (registered)
//   busy         - high during the page-fix cycle of a crossing branch
//   page_cross   - high during the page-fix cycle of a crossing branch
// ADDR_W must be a multiple of LANE_W and at least 2*LANE_W.
module program_counter_ext
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W      = 16,
  parameter int                 LANE_W      = PC_LANE_W,
  parameter logic [ADDR_W-1:0]  RESET_VALUE = ADDR_W'(PC_RESET_VECTOR),
  localparam int                LANES       = ADDR_W / LANE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [LANES-1:0]  lane_load,
  input  logic              inc_enable,
  input  logic              branch,
  input  logic [LANE_W-1:0] offset,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              page_cross
);

  localparam int UPPER_W = ADDR_W - LANE_W;

  pc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              dir_dec_q, dir_dec_d;
  logic              busy_q, busy_d;
  logic              page_cross_q, page_cross_d;

  logic [LANE_W-1:0] lane_sum_s;
  fix_dir_t          fix_dir_s;
  logic              load_any_s;
  logic [UPPER_W-1:0] upper_s;

  // Replace the masked lanes of cur with the matching lanes of din.
  function automatic logic [ADDR_W-1:0] apply_lane_load(
    input logic [ADDR_W-1:0] cur,
    input logic [ADDR_W-1:0] din,
    input logic [LANES-1:0]  mask
  );
    logic [ADDR_W-1:0] res;
    res = cur;
    for (int k = 0; k < LANES; k++) begin
      if (mask[k]) begin
        res[k*LANE_W +: LANE_W] = din[k*LANE_W +: LANE_W];
      end else begin
        res[k*LANE_W +: LANE_W] = cur[k*LANE_W +: LANE_W];
      end
    end
    return res;
  endfunction

  pc_lane_adder #(
    .LANE_W (LANE_W)
  ) u_lane_adder (
    .lane_in (pc_q[LANE_W-1:0]),
    .offset  (offset),
    .sum     (lane_sum_s),
    .fix_dir (fix_dir_s)
  );

  assign load_any_s = (lane_load != {LANES{1'b0}});
  assign upper_s    = pc_q[ADDR_W-1:LANE_W];

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_VALUE;
      dir_dec_q    <= 1'b0;
      busy_q       <= 1'b0;
      page_cross_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      dir_dec_q    <= dir_dec_d;
      busy_q       <= busy_d;
      page_cross_q <= page_cross_d;
    end
  end

  // Next-state logic: only a page-crossing branch (without a load) enters FIX.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (load_any_s) begin
          state_d = RUN;
        end else if (branch && (fix_dir_s != FIX_NONE)) begin
          state_d = FIX;
        end else begin
          state_d = RUN;
        end
      end
      FIX:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Datapath next values and flags, prioritised load > branch > inc > hold.
  always_comb begin
    pc_d         = pc_q;
    dir_dec_d    = dir_dec_q;
    busy_d       = 1'b0;
    page_cross_d = 1'b0;
    case (state_q)
      RUN: begin
        if (load_any_s) begin
          pc_d = apply_lane_load(pc_q, pc_in, lane_load);
        end else if (branch) begin
          pc_d[LANE_W-1:0] = lane_sum_s;
          if (fix_dir_s != FIX_NONE) begin
            dir_dec_d    = (fix_dir_s == FIX_DEC);
            busy_d       = 1'b1;
            page_cross_d = 1'b1;
          end else begin
            dir_dec_d = dir_dec_q;
          end
        end else if (inc_enable) begin
          pc_d = pc_q + ADDR_W'(1);
        end else begin
          pc_d = pc_q;
        end
      end
      FIX: begin
        // A load abandons the pending fix; branch/inc are ignored here.
        if (load_any_s) begin
          pc_d = apply_lane_load(pc_q, pc_in, lane_load);
        end else if (dir_dec_q) begin
          pc_d[ADDR_W-1:LANE_W] = upper_s - UPPER_W'(1);
        end else begin
          pc_d[ADDR_W-1:LANE_W] = upper_s + UPPER_W'(1);
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  assign pc_out     = pc_q;
  assign busy       = busy_q;
  assign page_cross = page_cross_q;

endmodule
